// File: rtl/char_console_pkg.sv
// Shared geometry, control codes and FSM state encoding for the character console.
package char_console_pkg;

    localparam int COLS   = 16;
    localparam int ROWS   = 4;
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = $clog2(CELLS);
    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);

    localparam logic [7:0] CC_CR       = 8'h0D;
    localparam logic [7:0] CC_LF       = 8'h0A;
    localparam logic [7:0] CC_BS       = 8'h08;
    localparam logic [7:0] CC_FF       = 8'h0C;
    localparam logic [7:0] CHAR_SPACE  = 8'h20;
    localparam logic [7:0] CHAR_CURSOR = 8'h5F;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SCROLL_COPY = 2'd1,
        SCROLL_CLR  = 2'd2,
        CLEAR       = 2'd3
    } state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/console_char_ram.sv
// 64x8 character store: one sync write port, a combinational read for the scroll
// source and a registered read for the display. Every cell resets to a space.
module console_char_ram
    import char_console_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] sweep_addr_i,
    output logic [7:0]        sweep_data_o,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o
);

    logic [7:0] mem_q [CELLS];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CELLS; i++) begin
                mem_q[i] <= CHAR_SPACE;
            end
            rd_data_q <= CHAR_SPACE;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign sweep_data_o = mem_q[sweep_addr_i];
    assign rd_data_o    = rd_data_q;

endmodule

// File: rtl/char_console.sv
// Terminal-style text front end: byte stream decode, cursor tracking, scroll and clear.
// Optional cursor blink overlay on the read port when CURSOR_BLINK_EN is defined.
module char_console
    import char_console_pkg::*;
#(
    parameter int BLINK_CYCLES = 13500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [ADDR_W-1:0] cursor_pos,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [ADDR_W-1:0] COPY_LAST     = ADDR_W'((ROWS - 1) * COLS - 1);
    localparam logic [ADDR_W-1:0] CLR_LAST      = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] CELL_LAST     = ADDR_W'(CELLS - 1);
    localparam logic [COL_W-1:0]  COL_LAST      = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST      = ROW_W'(ROWS - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;

    logic              accept;
    logic              printable;
    logic              row_adv;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;
    logic [ADDR_W-1:0] sweep_addr;
    logic [7:0]        sweep_data;
    logic [7:0]        ram_rd_data;

    // Held low through reset so no byte is ever handshaken while rst_n is asserted.
    assign in_ready   = rst_n & (state_q == IDLE) & ~wr_en;
    assign accept     = in_valid & in_ready;
    assign printable  = is_printable(in_data);
    assign row_adv    = accept & ((printable & (col_q == COL_LAST)) | (in_data == CC_LF));
    assign cursor_pos = {row_q, col_q};
    assign busy       = (state_q != IDLE);
    assign sweep_addr = idx_q + ADDR_W'(COLS);

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_addr;
        ram_wdata = wr_data;
        if (wr_en) begin
            ram_we = 1'b1;
        end else begin
            case (state_q)
                SCROLL_COPY: begin
                    ram_we    = 1'b1;
                    ram_waddr = idx_q;
                    ram_wdata = sweep_data;
                end
                SCROLL_CLR: begin
                    ram_we    = 1'b1;
                    ram_waddr = LAST_ROW_BASE + idx_q;
                    ram_wdata = CHAR_SPACE;
                end
                CLEAR: begin
                    ram_we    = 1'b1;
                    ram_waddr = idx_q;
                    ram_wdata = CHAR_SPACE;
                end
                default: begin
                    if (accept && printable) begin
                        ram_we    = 1'b1;
                        ram_waddr = cursor_pos;
                        ram_wdata = in_data;
                    end else if (accept && (in_data == CC_BS) && (col_q != '0)) begin
                        ram_we    = 1'b1;
                        ram_waddr = {row_q, col_q - 1'b1};
                        ram_wdata = CHAR_SPACE;
                    end
                end
            endcase
        end
    end

    // A direct write steals the port, so the sweep index holds rather than skip a cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
                        end else if (in_data == CC_CR || in_data == CC_LF) begin
                            col_q <= '0;
                        end else if (in_data == CC_BS) begin
                            if (col_q != '0) col_q <= col_q - 1'b1;
                        end else if (in_data == CC_FF) begin
                            state_q <= CLEAR;
                            idx_q   <= '0;
                        end
                        if (row_adv) begin
                            if (row_q == ROW_LAST) begin
                                state_q <= SCROLL_COPY;
                                idx_q   <= '0;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end
                    end
                end
                SCROLL_COPY: begin
                    if (!wr_en) begin
                        if (idx_q == COPY_LAST) begin
                            state_q <= SCROLL_CLR;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                SCROLL_CLR: begin
                    if (!wr_en) begin
                        if (idx_q == CLR_LAST) begin
                            state_q <= IDLE;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    if (!wr_en) begin
                        if (idx_q == CELL_LAST) begin
                            state_q <= IDLE;
                            idx_q   <= '0;
                            row_q   <= '0;
                            col_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    console_char_ram u_ram (
        .clk          (clk),
        .rst_n        (rst_n),
        .we_i         (ram_we),
        .waddr_i      (ram_waddr),
        .wdata_i      (ram_wdata),
        .sweep_addr_i (sweep_addr),
        .sweep_data_o (sweep_data),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (ram_rd_data)
    );

`ifdef CURSOR_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);

    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_q;
    logic               cursor_hit_q;

    // Hit flag is registered alongside the RAM read to keep the 1-cycle read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            cursor_hit_q <= 1'b0;
        end else begin
            if (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1)) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
            cursor_hit_q <= blink_q && (state_q == IDLE) && (rd_addr == cursor_pos);
        end
    end

    assign rd_data = cursor_hit_q ? CHAR_CURSOR : ram_rd_data;
`else
    assign rd_data = ram_rd_data;
`endif

endmodule

// File: tb/tb_char_console.sv
// Directed self-checking bench for char_console: reset, stream decode, scroll, direct
// write arbitration, backspace, form feed and reset during a clear sweep.
module tb_char_console;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;
    logic [5:0] cursor_pos;
    logic       busy;

    int n_checks;
    int n_fail;

    char_console dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .cursor_pos (cursor_pos),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_cell(input int addr, output logic [7:0] data);
        rd_addr = 6'(addr);
        tick();
        data = rd_data;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        #1;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic count_busy(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check(tag, n, exp_cycles);
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(8'h41 + (i % 26));
    endfunction

    initial begin
        logic [7:0] d;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        wr_en    = 1'b0;
        wr_addr  = 6'd0;
        wr_data  = 8'h00;
        rd_addr  = 6'd0;

        #1 rst_n = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cursor", 32'(cursor_pos), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h20);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        for (int a = 0; a < 64; a++) begin
            read_cell(a, d);
            check("rst_cell_space", 32'(d), 32'h20);
        end

        send_byte(8'h48);
        send_byte(8'h49);
        send_byte(8'h0D);
        check("hi_cr_cursor", 32'(cursor_pos), 32'd0);
        read_cell(0, d);
        check("hi_cell0", 32'(d), 32'h48);
        read_cell(1, d);
        check("hi_cell1", 32'(d), 32'h49);

        for (int i = 0; i < 64; i++) begin
            send_byte(pat(i));
        end
        check("scroll_busy", 32'(busy), 32'd1);
        check("scroll_in_ready", 32'(in_ready), 32'd0);
        check("scroll_cursor", 32'(cursor_pos), 32'd48);
        count_busy("scroll_busy_cycles", 64);
        for (int c = 0; c < 16; c++) begin
            read_cell(c, d);
            check("scroll_row0", 32'(d), 32'(pat(16 + c)));
        end
        read_cell(16 + 7, d);
        check("scroll_row1", 32'(d), 32'(pat(32 + 7)));
        read_cell(32 + 15, d);
        check("scroll_row2", 32'(d), 32'(pat(48 + 15)));
        for (int c = 0; c < 16; c++) begin
            read_cell(48 + c, d);
            check("scroll_row3_space", 32'(d), 32'h20);
        end
        check("scroll_cursor_after", 32'(cursor_pos), 32'd48);

        wr_en    = 1'b1;
        wr_addr  = 6'd10;
        wr_data  = 8'h2A;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        #1;
        check("wr_blocks_ready", 32'(in_ready), 32'd0);
        tick();
        wr_en = 1'b0;
        #1;
        check("wr_released_ready", 32'(in_ready), 32'd1);
        check("wr_cursor_held", 32'(cursor_pos), 32'd48);
        tick();
        in_valid = 1'b0;
        check("wr_stream_cursor", 32'(cursor_pos), 32'd49);
        read_cell(10, d);
        check("wr_cell10", 32'(d), 32'h2A);
        read_cell(48, d);
        check("wr_stream_cell48", 32'(d), 32'h5A);

        send_byte(8'h0D);
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
        send_byte(8'h64);
        send_byte(8'h65);
        check("bs_pre_cursor", 32'(cursor_pos), 32'd53);
        send_byte(8'h08);
        check("bs_cursor", 32'(cursor_pos), 32'd52);
        read_cell(52, d);
        check("bs_cell", 32'(d), 32'h20);
        read_cell(51, d);
        check("bs_prev_cell", 32'(d), 32'h64);
        send_byte(8'h0D);
        send_byte(8'h08);
        check("bs_col0_cursor", 32'(cursor_pos), 32'd48);
        check("bs_col0_busy", 32'(busy), 32'd0);
        read_cell(48, d);
        check("bs_col0_cell", 32'(d), 32'h61);
        send_byte(8'h01);
        check("drop_cursor", 32'(cursor_pos), 32'd48);
        check("drop_in_ready", 32'(in_ready), 32'd1);

        send_byte(8'h0C);
        check("ff_busy", 32'(busy), 32'd1);
        count_busy("ff_busy_cycles", 64);
        check("ff_cursor", 32'(cursor_pos), 32'd0);
        for (int a = 0; a < 64; a++) begin
            read_cell(a, d);
            check("ff_cell_space", 32'(d), 32'h20);
        end

        send_byte(8'h0A);
        check("lf_cursor", 32'(cursor_pos), 32'd16);
        send_byte(8'h51);
        check("q_cursor", 32'(cursor_pos), 32'd17);
        rd_addr = 6'd16;
        send_byte(8'h0C);
        for (int i = 0; i < 10; i++) tick();
        check("midclr_busy", 32'(busy), 32'd1);
        check("midclr_cursor", 32'(cursor_pos), 32'd17);
        check("midclr_cell16", 32'(rd_data), 32'h51);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_cursor", 32'(cursor_pos), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_rd_data", 32'(rd_data), 32'h20);
        tick();
        rst_n = 1'b1;
        tick();
        read_cell(16, d);
        check("arst_cell16", 32'(d), 32'h20);
        check("arst_busy_after", 32'(busy), 32'd0);
        check("arst_in_ready_after", 32'(in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
